// File: rtl/rw_cmd_seq_pkg.sv
// Shared definitions for the read/write command sequencer:
//   state_t        - sequencer state codes (also exported on state_o for debug)
//   DEF_CMD_*      - default command strobe patterns for each state
//   clog2          - ceiling log2, used to size counters
package rw_cmd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_S1 = 3'd1,
    WR_S2 = 3'd2,
    RD_S1 = 3'd3,
    RD_S2 = 3'd4
  } state_t;

  localparam logic [2:0] DEF_CMD_IDLE = 3'b111;
  localparam logic [2:0] DEF_CMD_WR1  = 3'b011;
  localparam logic [2:0] DEF_CMD_WR2  = 3'b101;
  localparam logic [2:0] DEF_CMD_RD1  = 3'b011;
  localparam logic [2:0] DEF_CMD_RD2  = 3'b110;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rw_cmd_seq_phase_timer.sv
// Phase timer shared by all sequencer states.
//   clk, rst  - clock, asynchronous active-low reset
//   load      - load load_val this cycle (state entry)
//   load_val  - phase length minus one
//   zero      - counter has reached zero: current phase ends this cycle
module phase_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rw_cmd_seq.sv
// Read/write command sequencer. Each beat drives cmd through two phases
// (S1 then S2) of configurable length; bursts run 1..2^BURST_W beats.
// A write requested during a read preempts it at the next beat boundary.
//   clk, rst   - clock, asynchronous active-low reset
//   wr_req     - write request (level), sampled in IDLE and during reads
//   rd_req     - read request (level), sampled in IDLE only
//   burst_len  - beats for the accepted request, 0 means 2^BURST_W
//   cmd        - registered command strobes
//   busy       - sequencer not in IDLE
//   is_wr      - sequencer in a write phase
//   done       - one-cycle pulse after the last phase of the last beat
//   rd_abort   - one-cycle pulse when a read burst is cut short by a write
//   state_o    - current state code
module rw_cmd_seq
  import rw_cmd_seq_pkg::*;
#(
  parameter int unsigned      CMD_W      = 3,
  parameter int unsigned      BURST_W    = 4,
  parameter int unsigned      WR_PH1_CYC = 1,
  parameter int unsigned      WR_PH2_CYC = 1,
  parameter int unsigned      RD_PH1_CYC = 1,
  parameter int unsigned      RD_PH2_CYC = 1,
  parameter logic [CMD_W-1:0] CMD_IDLE   = DEF_CMD_IDLE,
  parameter logic [CMD_W-1:0] CMD_WR1    = DEF_CMD_WR1,
  parameter logic [CMD_W-1:0] CMD_WR2    = DEF_CMD_WR2,
  parameter logic [CMD_W-1:0] CMD_RD1    = DEF_CMD_RD1,
  parameter logic [CMD_W-1:0] CMD_RD2    = DEF_CMD_RD2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_req,
  input  logic               rd_req,
  input  logic [BURST_W-1:0] burst_len,
  output logic [CMD_W-1:0]   cmd,
  output logic               busy,
  output logic               is_wr,
  output logic               done,
  output logic               rd_abort,
  output logic [2:0]         state_o
);

  localparam int unsigned PH_MAX_W = (WR_PH1_CYC > WR_PH2_CYC) ? WR_PH1_CYC : WR_PH2_CYC;
  localparam int unsigned PH_MAX_R = (RD_PH1_CYC > RD_PH2_CYC) ? RD_PH1_CYC : RD_PH2_CYC;
  localparam int unsigned PH_MAX   = (PH_MAX_W > PH_MAX_R) ? PH_MAX_W : PH_MAX_R;
  localparam int unsigned TW       = clog2(PH_MAX + 1);
  localparam int unsigned BCW      = BURST_W + 1;

  state_t           state, state_nx;
  logic [BCW-1:0]   beats, beats_nx, beat_load;
  logic             pend, pend_nx, pend_eff, last_beat;
  logic             ph_load, ph_zero;
  logic [TW-1:0]    ph_val;
  logic [CMD_W-1:0] cmd_nx;
  logic             done_nx, abort_nx;

  assign beat_load = (burst_len == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, burst_len};
  assign last_beat = (beats == BCW'(1));
  // A write arriving in the final RD_S2 cycle still takes this boundary.
  assign pend_eff  = pend | wr_req;

  always_comb begin
    state_nx = state;
    beats_nx = beats;
    pend_nx  = pend;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          state_nx = WR_S1;
          beats_nx = beat_load;
        end else if (rd_req) begin
          state_nx = RD_S1;
          beats_nx = beat_load;
        end
      end
      WR_S1: if (ph_zero) state_nx = WR_S2;
      WR_S2: begin
        if (ph_zero) begin
          beats_nx = beats - BCW'(1);
          if (!last_beat) begin
            state_nx = WR_S1;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      RD_S1: begin
        if (wr_req) pend_nx = 1'b1;
        if (ph_zero) state_nx = RD_S2;
      end
      RD_S2: begin
        if (wr_req) pend_nx = 1'b1;
        if (ph_zero) begin
          if (pend_eff) begin
            state_nx = WR_S1;
            beats_nx = beat_load;
            done_nx  = last_beat;
            abort_nx = !last_beat;
          end else if (!last_beat) begin
            state_nx = RD_S1;
            beats_nx = beats - BCW'(1);
          end else begin
            state_nx = IDLE;
            beats_nx = beats - BCW'(1);
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == WR_S1) pend_nx = 1'b0;
  end

  // Timer reloads on every state change with the incoming state's length.
  always_comb begin
    ph_load = (state_nx != state);
    cmd_nx  = CMD_IDLE;
    ph_val  = '0;
    case (state_nx)
      WR_S1: begin cmd_nx = CMD_WR1; ph_val = TW'(WR_PH1_CYC - 1); end
      WR_S2: begin cmd_nx = CMD_WR2; ph_val = TW'(WR_PH2_CYC - 1); end
      RD_S1: begin cmd_nx = CMD_RD1; ph_val = TW'(RD_PH1_CYC - 1); end
      RD_S2: begin cmd_nx = CMD_RD2; ph_val = TW'(RD_PH2_CYC - 1); end
      default: begin cmd_nx = CMD_IDLE; ph_val = '0; end
    endcase
  end

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beats    <= '0;
      pend     <= 1'b0;
      cmd      <= CMD_IDLE;
      busy     <= 1'b0;
      is_wr    <= 1'b0;
      done     <= 1'b0;
      rd_abort <= 1'b0;
    end else begin
      state    <= state_nx;
      beats    <= beats_nx;
      pend     <= pend_nx;
      cmd      <= cmd_nx;
      busy     <= (state_nx != IDLE);
      is_wr    <= (state_nx == WR_S1) || (state_nx == WR_S2);
      done     <= done_nx;
      rd_abort <= abort_nx;
    end
  end

  assign state_o = state;

endmodule

// File: doc/rw_cmd_seq.md
Name: rw_cmd_seq

Overview:
Parametrised read/write command sequencer that drives a CMD_W-bit strobe bus through a two-phase pattern per beat, for bursts of 1..2^BURST_W beats. It replaces the fixed single-beat write/read sequencer in the control path, and adds the following:
- Configurable phase lengths.
- Burst counting.
- Write preemption of reads at beat boundaries.
- Busy/done/abort status.
It sits between the request arbiter and the external device pins.

Parameters:
CMD_W, 3, width of cmd bus
BURST_W, 4, width of burst_len; burst_len=0 means 2^BURST_W beats
WR_PH1_CYC, 1, cycles in WR_S1 (>=1)
WR_PH2_CYC, 1, cycles in WR_S2 (>=1)
RD_PH1_CYC, 1, cycles in RD_S1 (>=1)
RD_PH2_CYC, 1, cycles in RD_S2 (>=1)
CMD_IDLE, 3'b111, cmd value in IDLE
CMD_WR1, 3'b011, cmd value in WR_S1
CMD_WR2, 3'b101, cmd value in WR_S2
CMD_RD1, 3'b011, cmd value in RD_S1
CMD_RD2, 3'b110, cmd value in RD_S2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
wr_req  in  1  write request, level; sampled in IDLE and during reads
rd_req  in  1  read request, level; sampled in IDLE only
burst_len  in  BURST_W  beats for the accepted request; latched on acceptance
cmd  out  CMD_W  registered command strobes
busy  out  1  high in any non-IDLE state
is_wr  out  1  high while in WR_S1/WR_S2
done  out  1  one-cycle pulse on the cycle after the last phase of the last beat
rd_abort  out  1  one-cycle pulse when a read burst is cut short by a write
state_o  out  3  current state code, for debug

Behaviour:
- Reset (async, rst=0): state=IDLE, cmd=CMD_IDLE, busy=0, is_wr=0, done=0, rd_abort=0, all counters 0, pending_wr=0.
- States: IDLE=0, WR_S1=1, WR_S2=2, RD_S1=3, RD_S2=4. Codes must be distinct; encodings 5-7 are illegal and recover to IDLE with cmd=CMD_IDLE.
- All outputs are registered. cmd reflects the state entered on the same edge, so there is zero extra latency between state and cmd.
- IDLE:
  - wr_req=1 -> WR_S1, latch burst_len. Write has priority over a simultaneous rd_req.
  - Else rd_req=1 -> RD_S1, latch burst_len.
  - Else stay in IDLE.
  - First command cycle is the cycle after the request is sampled.
- Phase counter: loads PHx_CYC-1 on state entry and decrements each cycle; the state exits when it reaches 0. Each state therefore lasts exactly PHx_CYC cycles.
- WR_S1 -> WR_S2 on phase end.
- WR_S2 end of phase:
  - Beats remaining -> WR_S1.
  - Otherwise -> IDLE with done=1.
  - wr_req is not re-sampled until IDLE.
- RD_S1 -> RD_S2 on phase end.
- During a read, wr_req=1 on any cycle sets pending_wr. pending_wr is cleared on entering WR_S1.
- RD_S2 end of phase:
  - pending_wr=1 and beats remain -> WR_S1 with rd_abort=1 (pulse on the entry cycle). The write burst latches the current burst_len.
  - pending_wr=1 and this was the last beat -> WR_S1 with done=1 for the read; rd_abort=0.
  - pending_wr=0 and beats remain -> RD_S1.
  - Otherwise -> IDLE with done=1.
- Beat counter: width BURST_W+1, loaded with burst_len (0 -> 2^BURST_W), decremented at the end of each S2 phase.
- The hold-off in the last-beat-with-pending-write case is one write burst; the write is not re-arbitrated against rd_req.
- Reset mid-burst: immediate return to IDLE with cmd=CMD_IDLE; no done or rd_abort pulse.
- done and rd_abort are never high for more than one cycle and are never both high.

Decomposition:
- Package rw_cmd_seq_pkg holds:
  - the state enum/localparams (IDLE..RD_S2);
  - the default CMD_* codes;
  - a clog2 function for counter widths.
- One natural sub-module: phase_timer (load value, decrement, zero flag), instantiated once and shared across states.

Test Plan:
- Defaults; wr_req pulse with burst_len=1 -> cmd sequence 111,011,101,111; done high on the cycle cmd returns to 111; busy high for 2 cycles.
- RD_PH2_CYC=3; rd_req with burst_len=2 -> cmd sequence 011,110,110,110,011,110,110,110,111; done once at the end; is_wr=0 throughout.
- wr_req and rd_req both asserted in IDLE -> WR_S1 entered; cmd=011, is_wr=1.
- Read with burst_len=4; wr_req pulsed in beat 2 RD_S1 -> after beat 2 RD_S2 go to WR_S1, rd_abort=1 for one cycle; the write burst completes with done.
- rst pulled low during WR_S2 of a 3-beat write -> cmd=111, busy=0 asynchronously; no done; the next rd_req starts cleanly.
- burst_len=0, BURST_W=2 -> exactly 4 write beats before done.
